// File: rtl/ethii_unpacker.sv
// Ethernet II receive unpacker: strips the 14-byte header onto a handshake port
// and realigns the payload by 16 bits so payload byte 0 lands in bits [31:24].
module ethii_unpacker (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ethii_tdata_i,
    input  logic        ethii_tvld_i,
    input  logic        ethii_tlast_i,
    input  logic [3:0]  ethii_tkeep_i,
    output logic        ethii_trdy_o,
    output logic [47:0] hdr_mac_dest_o,
    output logic [47:0] hdr_mac_src_o,
    output logic [15:0] hdr_mac_type_o,
    output logic        hdr_mac_vld_o,
    input  logic        hdr_mac_rdy_i,
    output logic [31:0] user_tdata_o,
    output logic        user_tvld_o,
    output logic        user_tlast_o,
    output logic [3:0]  user_tkeep_o,
    input  logic        user_trdy_i,
    output logic        err_runt_o
);

    typedef enum logic [2:0] {
        S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_DATA, S_FLUSH
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
    logic [47:0] dest_q, dest_d, src_q, src_d;
    logic [15:0] type_q, type_d;
    logic        hvld_q, hvld_d;
    logic [15:0] saved_q, saved_d;
    logic        flush_one_q, flush_one_d;
    logic [31:0] odata_q, odata_d;
    logic [3:0]  okeep_q, okeep_d;
    logic        olast_q, olast_d, ovld_q, ovld_d;
    logic        runt_q, runt_d;

    logic        out_rdy, in_rdy, beat, emit, emit_last;
    logic [31:0] emit_data, keep_mask;
    logic [3:0]  emit_keep;

    assign out_rdy = ~ovld_q | user_trdy_i;

    always_comb begin
        in_rdy = 1'b0;
        case (state_q)
            S_HDR0, S_HDR1, S_HDR2: in_rdy = 1'b1;
            S_HDR3:                 in_rdy = (~hvld_q | hdr_mac_rdy_i) & out_rdy;
            S_DATA:                 in_rdy = out_rdy;
            default:                in_rdy = 1'b0;
        endcase
    end

    assign ethii_trdy_o = in_rdy & reset_n;
    assign beat = ethii_tvld_i & in_rdy;

    always_comb begin
        state_d     = state_q;
        w0_d        = w0_q;
        w1_d        = w1_q;
        w2_d        = w2_q;
        dest_d      = dest_q;
        src_d       = src_q;
        type_d      = type_q;
        hvld_d      = hvld_q;
        saved_d     = saved_q;
        flush_one_d = flush_one_q;
        odata_d     = odata_q;
        okeep_d     = okeep_q;
        olast_d     = olast_q;
        ovld_d      = ovld_q;
        runt_d      = 1'b0;
        emit        = 1'b0;
        emit_data   = 32'h0;
        emit_keep   = 4'b0000;
        emit_last   = 1'b0;

        if (hvld_q & hdr_mac_rdy_i) hvld_d = 1'b0;

        case (state_q)
            S_HDR0: if (beat) begin
                w0_d = ethii_tdata_i;
                if (ethii_tlast_i) runt_d = 1'b1;
                else               state_d = S_HDR1;
            end
            S_HDR1: if (beat) begin
                w1_d = ethii_tdata_i;
                if (ethii_tlast_i) begin runt_d = 1'b1; state_d = S_HDR0; end
                else                     state_d = S_HDR2;
            end
            S_HDR2: if (beat) begin
                w2_d = ethii_tdata_i;
                if (ethii_tlast_i) begin runt_d = 1'b1; state_d = S_HDR0; end
                else                     state_d = S_HDR3;
            end
            S_HDR3: if (beat) begin
                // A last W3 carrying no payload byte is a runt: the header is never presented.
                if (ethii_tlast_i && ethii_tkeep_i != 4'b1111 && ethii_tkeep_i != 4'b1110) begin
                    runt_d  = 1'b1;
                    state_d = S_HDR0;
                end else begin
                    dest_d  = {w0_q, w1_q[31:16]};
                    src_d   = {w1_q[15:0], w2_q};
                    type_d  = ethii_tdata_i[31:16];
                    hvld_d  = 1'b1;
                    saved_d = ethii_tdata_i[15:0];
                    if (!ethii_tlast_i) begin
                        state_d = S_DATA;
                    end else begin
                        emit      = 1'b1;
                        emit_data = {ethii_tdata_i[15:0], 16'h0};
                        emit_keep = (ethii_tkeep_i == 4'b1111) ? 4'b1100 : 4'b1000;
                        emit_last = 1'b1;
                        state_d   = S_HDR0;
                    end
                end
            end
            S_DATA: if (beat) begin
                emit      = 1'b1;
                emit_data = {saved_q, ethii_tdata_i[31:16]};
                emit_keep = 4'b1111;
                saved_d   = ethii_tdata_i[15:0];
                if (ethii_tlast_i) begin
                    case (ethii_tkeep_i)
                        4'b1000: begin emit_keep = 4'b1110; emit_last = 1'b1; state_d = S_HDR0; end
                        4'b1100: begin emit_last = 1'b1; state_d = S_HDR0; end
                        4'b1110: begin flush_one_d = 1'b1; state_d = S_FLUSH; end
                        default: begin flush_one_d = 1'b0; state_d = S_FLUSH; end
                    endcase
                end
            end
            S_FLUSH: if (out_rdy) begin
                emit      = 1'b1;
                emit_data = {saved_q, 16'h0};
                emit_keep = flush_one_q ? 4'b1000 : 4'b1100;
                emit_last = 1'b1;
                state_d   = S_HDR0;
            end
            default: state_d = S_HDR0;
        endcase

        keep_mask = {{8{emit_keep[3]}}, {8{emit_keep[2]}}, {8{emit_keep[1]}}, {8{emit_keep[0]}}};
        if (out_rdy) begin
            ovld_d = emit;
            if (emit) begin
                odata_d = emit_data & keep_mask;
                okeep_d = emit_keep;
                olast_d = emit_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_HDR0;
            w0_q        <= 32'h0;
            w1_q        <= 32'h0;
            w2_q        <= 32'h0;
            dest_q      <= 48'h0;
            src_q       <= 48'h0;
            type_q      <= 16'h0;
            hvld_q      <= 1'b0;
            saved_q     <= 16'h0;
            flush_one_q <= 1'b0;
            odata_q     <= 32'h0;
            okeep_q     <= 4'b0000;
            olast_q     <= 1'b0;
            ovld_q      <= 1'b0;
            runt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            w0_q        <= w0_d;
            w1_q        <= w1_d;
            w2_q        <= w2_d;
            dest_q      <= dest_d;
            src_q       <= src_d;
            type_q      <= type_d;
            hvld_q      <= hvld_d;
            saved_q     <= saved_d;
            flush_one_q <= flush_one_d;
            odata_q     <= odata_d;
            okeep_q     <= okeep_d;
            olast_q     <= olast_d;
            ovld_q      <= ovld_d;
            runt_q      <= runt_d;
        end
    end

    assign hdr_mac_dest_o = dest_q;
    assign hdr_mac_src_o  = src_q;
    assign hdr_mac_type_o = type_q;
    assign hdr_mac_vld_o  = hvld_q;
    assign user_tdata_o   = odata_q;
    assign user_tkeep_o   = okeep_q;
    assign user_tlast_o   = olast_q;
    assign user_tvld_o    = ovld_q;
    assign err_runt_o     = runt_q;

endmodule

// File: tb/tb_ethii_unpacker.sv
// Bench for ethii_unpacker: table of frame lengths plus hand sequences, all checked
// against a byte-level frame model (header = bytes 0..13, payload = bytes 14..end).
module tb_ethii_unpacker;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [31:0] tdata;
    logic        tvld, tlast, trdy;
    logic [3:0]  tkeep;
    logic [47:0] hdest, hsrc;
    logic [15:0] htype;
    logic        hvld, hrdy;
    logic [31:0] udata;
    logic        uvld, ulast, urdy;
    logic [3:0]  ukeep;
    logic        err_runt;

    ethii_unpacker dut (
        .clk(clk), .reset_n(reset_n),
        .ethii_tdata_i(tdata), .ethii_tvld_i(tvld), .ethii_tlast_i(tlast),
        .ethii_tkeep_i(tkeep), .ethii_trdy_o(trdy),
        .hdr_mac_dest_o(hdest), .hdr_mac_src_o(hsrc), .hdr_mac_type_o(htype),
        .hdr_mac_vld_o(hvld), .hdr_mac_rdy_i(hrdy),
        .user_tdata_o(udata), .user_tvld_o(uvld), .user_tlast_o(ulast),
        .user_tkeep_o(ukeep), .user_trdy_i(urdy),
        .err_runt_o(err_runt)
    );

    typedef logic [7:0] bytes_t[$];
    typedef struct {
        int len;
        int exp_words;
        int exp_runt;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int urdy_mode = 0;   // 0 always ready, 1 random, 2 held low
    int hrdy_mode = 0;
    int runt_cycles = 0;
    logic [36:0]  out_q[$];   // {data, keep, last}
    logic [111:0] hdr_q[$];   // {dest, src, type}

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ready generators update at +2 so the main flow (at +1) never races them.
    initial begin
        urdy = 1'b1;
        hrdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            urdy = (urdy_mode == 0) ? 1'b1 : (urdy_mode == 1) ? ($urandom_range(0, 99) < 60) : 1'b0;
            hrdy = (hrdy_mode == 0) ? 1'b1 : (hrdy_mode == 1) ? ($urandom_range(0, 99) < 50) : 1'b0;
        end
    end

    // Monitor: collects handshakes and checks that stalled outputs hold.
    initial begin
        logic          prev_ustall, prev_hstall;
        logic [36:0]   prev_u;
        logic [111:0]  prev_h;
        prev_ustall = 1'b0;
        prev_hstall = 1'b0;
        prev_u = '0;
        prev_h = '0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (prev_ustall) check("user_hold", {uvld, udata, ukeep, ulast}, {1'b1, prev_u});
                if (prev_hstall) check("hdr_hold", {hvld, hdest, hsrc, htype}, {1'b1, prev_h});
                if (uvld && urdy) out_q.push_back({udata, ukeep, ulast});
                if (hvld && hrdy) hdr_q.push_back({hdest, hsrc, htype});
                if (err_runt) runt_cycles++;
                prev_ustall = uvld && !urdy;
                prev_hstall = hvld && !hrdy;
                prev_u = {udata, ukeep, ulast};
                prev_h = {hdest, hsrc, htype};
            end else begin
                prev_ustall = 1'b0;
                prev_hstall = 1'b0;
            end
        end
    end

    task automatic drive_word(input logic [31:0] d, input logic [3:0] k, input logic l, input int gap);
        int   n;
        logic acc;
        while (gap > 0 && $urandom_range(0, 99) < gap) begin
            tvld = 1'b0;
            tick();
        end
        tvld = 1'b1; tdata = d; tkeep = k; tlast = l;
        n = 0;
        acc = 1'b0;
        do begin
            @(negedge clk);
            acc = trdy;
            tick();
            n++;
        end while (!acc && n < 400);
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout actual=no_accept required=accept word=%0h", d);
        end
        tvld = 1'b0;
        tlast = 1'b0;
    endtask

    task automatic send_frame(input bytes_t fb, input int gap);
        int nw, idx;
        logic [31:0] d;
        logic [3:0]  k;
        nw = (fb.size() + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < 4; b++) begin
                idx = 4 * w + b;
                if (idx < fb.size()) begin
                    d[31-8*b -: 8] = fb[idx];
                    k[3-b] = 1'b1;
                end else begin
                    d[31-8*b -: 8] = 8'($urandom);
                    k[3-b] = 1'b0;
                end
            end
            if (w != nw - 1) k = 4'($urandom);
            drive_word(d, k, (w == nw - 1), gap);
        end
    endtask

    task automatic send_plan(input logic [31:0] last_w, input logic [3:0] last_k);
        drive_word(32'h00112233, 4'hF, 1'b0, 0);
        drive_word(32'h44556677, 4'hF, 1'b0, 0);
        drive_word(32'h8899AABB, 4'hF, 1'b0, 0);
        drive_word(32'h08000102, 4'hF, 1'b0, 0);
        drive_word(32'h03040506, 4'hF, 1'b0, 0);
        drive_word(last_w, last_k, 1'b1, 0);
    endtask

    task automatic wait_out(input int nw, input int nh, input int nr);
        int n;
        n = 0;
        while ((out_q.size() < nw || hdr_q.size() < nh || runt_cycles < nr) && n < 1000) begin
            tick();
            n++;
        end
        repeat (6) tick();
    endtask

    task automatic clear_sb();
        out_q.delete();
        hdr_q.delete();
        runt_cycles = 0;
    endtask

    function automatic bytes_t mk_frame(input int len);
        bytes_t q;
        for (int i = 0; i < len; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Reference: a frame of L bytes is a runt iff L <= 14; otherwise the payload
    // bytes 14..L-1 are packed four per word, MSB first, invalid bytes zero.
    task automatic verify_frame(input string nm, input bytes_t fb, output int got_words, output int got_runt);
        int L, np, nw_exp, nh_exp, nr_exp, idx;
        logic [36:0]  ew;
        logic [111:0] eh;
        L = fb.size();
        nr_exp = (L <= 14) ? 1 : 0;
        nh_exp = 1 - nr_exp;
        np = nr_exp ? 0 : L - 14;
        nw_exp = (np + 3) / 4;
        wait_out(nw_exp, nh_exp, nr_exp);
        got_words = out_q.size();
        got_runt = runt_cycles;
        check({nm, "_nwords"}, out_q.size(), nw_exp);
        check({nm, "_nhdr"}, hdr_q.size(), nh_exp);
        check({nm, "_runt"}, runt_cycles, nr_exp);
        if (nh_exp == 1 && hdr_q.size() > 0) begin
            eh = '0;
            for (int i = 0; i < 14; i++) eh = {eh[103:0], fb[i]};
            check({nm, "_hdr"}, hdr_q[0], eh);
        end
        for (int w = 0; w < nw_exp && w < out_q.size(); w++) begin
            ew = '0;
            for (int b = 0; b < 4; b++) begin
                idx = 14 + 4 * w + b;
                if (idx < L) begin
                    ew[36-8*b -: 8] = fb[idx];
                    ew[4-b] = 1'b1;
                end
            end
            ew[0] = (w == nw_exp - 1);
            check($sformatf("%s_w%0d", nm, w), out_q[w], ew);
        end
        clear_sb();
    endtask

    localparam logic [111:0] PLAN_HDR = {48'h001122334455, 48'h66778899AABB, 16'h0800};

    vec_t   vecs[15];
    bytes_t fb, fb_b;
    int     gw, gr, n;
    logic   b_done;

    initial begin
        vecs[0]  = '{8,  0, 1};
        vecs[1]  = '{10, 0, 1};
        vecs[2]  = '{12, 0, 1};
        vecs[3]  = '{13, 0, 1};
        vecs[4]  = '{14, 0, 1};
        vecs[5]  = '{15, 1, 0};
        vecs[6]  = '{16, 1, 0};
        vecs[7]  = '{17, 1, 0};
        vecs[8]  = '{18, 1, 0};
        vecs[9]  = '{19, 2, 0};
        vecs[10] = '{20, 2, 0};
        vecs[11] = '{21, 2, 0};
        vecs[12] = '{22, 2, 0};
        vecs[13] = '{64, 13, 0};
        vecs[14] = '{78, 16, 0};

        reset_n = 1'b0;
        tvld = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0;
        repeat (3) tick();
        check("reset_trdy", trdy, 1'b0);
        check("reset_outputs", {uvld, udata, ukeep, ulast, hvld, hdest, hsrc, htype, err_runt}, '0);
        reset_n = 1'b1;
        tick();

        // Test-plan frame, last word keep 1100.
        send_plan(32'h0708DEAD, 4'b1100);
        wait_out(2, 1, 0);
        check("plan_nwords", out_q.size(), 2);
        check("plan_runt", runt_cycles, 0);
        if (hdr_q.size() > 0) check("plan_hdr", hdr_q[0], PLAN_HDR);
        if (out_q.size() > 1) begin
            check("plan_w0", out_q[0], {32'h01020304, 4'b1111, 1'b0});
            check("plan_w1", out_q[1], {32'h05060708, 4'b1111, 1'b1});
        end
        clear_sb();

        // Last word keep 1000.
        send_plan(32'h07ABCDEF, 4'b1000);
        wait_out(2, 1, 0);
        check("k1000_nwords", out_q.size(), 2);
        if (out_q.size() > 1) check("k1000_w1", out_q[1], {32'h05060700, 4'b1110, 1'b1});
        clear_sb();

        // Last word keep 1110: one leftover byte flushed, input stalled during FLUSH.
        send_plan(32'h0708095A, 4'b1110);
        check("flush_trdy", trdy, 1'b0);
        wait_out(3, 1, 0);
        check("k1110_nwords", out_q.size(), 3);
        if (out_q.size() > 2) begin
            check("k1110_w1", out_q[1], {32'h05060708, 4'b1111, 1'b0});
            check("k1110_w2", out_q[2], {32'h09000000, 4'b1000, 1'b1});
        end
        clear_sb();

        // Runt on W1, then a good frame.
        drive_word(32'h00112233, 4'hF, 1'b0, 0);
        drive_word(32'h44556677, 4'hF, 1'b1, 0);
        wait_out(0, 0, 1);
        check("runt_w1_pulse", runt_cycles, 1);
        check("runt_w1_out", {out_q.size(), hdr_q.size()}, 0);
        clear_sb();
        send_plan(32'h0708DEAD, 4'b1100);
        wait_out(2, 1, 0);
        if (hdr_q.size() > 0) check("after_runt_hdr", hdr_q[0], PLAN_HDR);
        check("after_runt_nwords", out_q.size(), 2);
        clear_sb();

        // Header back-pressure across two frames.
        hrdy_mode = 2;
        tick();
        tick();
        send_plan(32'h0708DEAD, 4'b1100);
        fb_b = mk_frame(30);
        b_done = 1'b0;
        fork
            begin
                send_frame(fb_b, 0);
                b_done = 1'b1;
            end
        join_none
        repeat (12) tick();
        check("stall_hvld", hvld, 1'b1);
        check("stall_hdr_a", {hdest, hsrc, htype}, PLAN_HDR);
        check("stall_w3_trdy", trdy, 1'b0);
        check("stall_payload_a", out_q.size(), 2);
        out_q.delete();
        hrdy_mode = 0;
        tick();
        begin
            logic [111:0] ehb;
            ehb = '0;
            for (int i = 0; i < 14; i++) ehb = {ehb[103:0], fb_b[i]};
            check("release_hdr_b", {hvld, hdest, hsrc, htype}, {1'b1, ehb});
        end
        n = 0;
        while (!b_done && n < 2000) begin
            tick();
            n++;
        end
        check("stall_b_done", b_done, 1'b1);
        repeat (3) tick();
        check("hdr_a_accepted", (hdr_q.size() > 0) ? hdr_q[0] : 112'h0, PLAN_HDR);
        if (hdr_q.size() > 0) void'(hdr_q.pop_front());
        verify_frame("stall_b", fb_b, gw, gr);

        // Table of frame lengths under random gaps and random back-pressure.
        urdy_mode = 1;
        hrdy_mode = 1;
        for (int v = 0; v < 15; v++) begin
            fb = mk_frame(vecs[v].len);
            send_frame(fb, 25);
            verify_frame($sformatf("len%0d", vecs[v].len), fb, gw, gr);
            check($sformatf("tbl%0d_words", vecs[v].len), gw, vecs[v].exp_words);
            check($sformatf("tbl%0d_runt", vecs[v].len), gr, vecs[v].exp_runt);
        end

        // Random frame lengths.
        for (int r = 0; r < 20; r++) begin
            fb = mk_frame($urandom_range(8, 80));
            send_frame(fb, $urandom_range(0, 40));
            verify_frame($sformatf("rnd%0d", r), fb, gw, gr);
        end

        // 64-byte payload under random user ready, then reset mid-frame.
        fb = mk_frame(78);
        send_frame(fb, 10);
        verify_frame("pay64", fb, gw, gr);
        urdy_mode = 2;
        hrdy_mode = 0;
        tick();
        tick();
        for (int w = 0; w < 5; w++) drive_word($urandom, 4'hF, 1'b0, 0);
        tick();
        check("pre_reset_uvld", uvld, 1'b1);
        reset_n = 1'b0;
        tick();
        check("midreset_trdy", trdy, 1'b0);
        tick();
        check("midreset_outputs", {uvld, udata, ukeep, ulast, hvld, hdest, hsrc, htype, err_runt}, '0);
        urdy_mode = 0;
        reset_n = 1'b1;
        tick();
        tick();
        clear_sb();
        send_plan(32'h0708DEAD, 4'b1100);
        wait_out(2, 1, 0);
        check("post_reset_runt", runt_cycles, 0);
        if (hdr_q.size() > 0) check("post_reset_hdr", hdr_q[0], PLAN_HDR);
        check("post_reset_nwords", out_q.size(), 2);
        if (out_q.size() > 1) begin
            check("post_reset_w0", out_q[0], {32'h01020304, 4'b1111, 1'b0});
            check("post_reset_w1", out_q[1], {32'h05060708, 4'b1111, 1'b1});
        end
        clear_sb();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ethii_unpacker.md
# ethii_unpacker

Receive-side counterpart of the Ethernet II packer. It accepts a 32-bit big-endian frame stream whose first 14 bytes are the Ethernet II header (destination MAC, source MAC, EtherType). It extracts the header onto a valid/ready header port. It realigns the payload by 16 bits onto a 32-bit user stream, so payload byte 0 lands in bits [31:24]. It sits between the MAC RX path and the IPv4/UDP parser.

## Interface
Parameters: none.

- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  reset; synchronous, active-low
- ethii_tdata_i  in  32  frame word, byte 0 in [31:24]
- ethii_tvld_i  in  1  input word valid
- ethii_tlast_i  in  1  last word of frame
- ethii_tkeep_i  in  4  byte enables, MSB-first; legal on last word: 1111/1110/1100/1000; ignored (taken as 1111) otherwise
- ethii_trdy_o  out  1  input ready (combinational)
- hdr_mac_dest_o  out  48  destination MAC
- hdr_mac_src_o  out  48  source MAC
- hdr_mac_type_o  out  16  EtherType
- hdr_mac_vld_o  out  1  header valid
- hdr_mac_rdy_i  in  1  header accepted
- user_tdata_o  out  32  payload word
- user_tvld_o  out  1  payload valid
- user_tlast_o  out  1  last payload word
- user_tkeep_o  out  4  payload byte enables, MSB-first
- user_trdy_i  in  1  payload ready
- err_runt_o  out  1  one-cycle pulse: frame dropped as runt

## Operation
- Input beat: ethii_tvld_i & ethii_trdy_o.
- Output register stage: out_rdy = ~user_tvld_o | user_trdy_i. An output register holds all user_* outputs and only loads when out_rdy is high.
- Header layout by word:
  - W0 = dest[47:16]
  - W1 = {dest[15:0], src[47:32]}
  - W2 = src[31:0]
  - W3 = {type, P0, P1}
- W0–W2 load shadow registers. hdr_mac_*_o load from the shadows and W3 together, so the presented header never changes while hdr_mac_vld_o is high.
- States:
  - HDR0, HDR1, HDR2: ethii_trdy_o = 1. Each beat advances one state. A beat with tlast pulses err_runt_o and returns to HDR0.
  - HDR3: ethii_trdy_o = (~hdr_mac_vld_o | hdr_mac_rdy_i) & out_rdy. On a beat:
    - Header is loaded and hdr_mac_vld_o is set.
    - saved ← tdata[15:0].
    - No tlast → DATA.
    - tlast with keep 1111 → emit {P0,P1,16'h0}, keep 1100, last → HDR0.
    - tlast with keep 1110 → emit {P0,8'h0,16'h0}, keep 1000, last → HDR0.
    - tlast with keep 1100/1000 (zero payload) → runt: no header, err_runt_o pulses → HDR0.
  - DATA: ethii_trdy_o = out_rdy. On a beat, emit {saved, tdata[31:16]} and set saved ← tdata[15:0].
    - No tlast → keep 1111, not last.
    - tlast, keep 1000 → out keep 1110, last → HDR0.
    - tlast, keep 1100 → out keep 1111, last → HDR0.
    - tlast, keep 1110 → out keep 1111, not last → FLUSH (1 leftover byte).
    - tlast, keep 1111 → out keep 1111, not last → FLUSH (2 leftover bytes).
  - FLUSH: ethii_trdy_o = 0. When out_rdy, emit {saved,16'h0}, last, keep 1100 (from 1111) or 1000 (from 1110) → HDR0.
- Invalid bytes of emitted words are driven to 0.
- hdr_mac_vld_o clears on hdr_mac_vld_o & hdr_mac_rdy_i, unless a new header loads in the same cycle (then it stays 1).
- Payload flow does not wait for header acceptance. Only the next frame's W3 waits.

## Timing
- Reset (reset_n low at a clk edge):
  - Forces state = HDR0, hdr_mac_vld_o = 0, user_tvld_o = 0, err_runt_o = 0.
  - user_tdata_o/user_tkeep_o/user_tlast_o = 0; header data outputs = 0.
  - ethii_trdy_o = 0 while reset_n is low.
  - A frame in progress is abandoned. No flush, no error pulse.
- Latency:
  - hdr_mac_vld_o rises 1 cycle after the W3 beat.
  - user_tvld_o rises 1 cycle after the beat that completes the word.
  - The FLUSH word follows the last-input-word output by ≥1 cycle.
- Throughput: one word per cycle in DATA, with no bubbles while user_trdy_i stays high. A frame with n total input words produces n−3 or n−4 output words (n−4 if the last word has ≤2 valid bytes).
- Back-to-back frames: HDR0 accepts the next W0 in the cycle after the last beat or flush.
- Stall: while user_tvld_o & ~user_trdy_i, all user_* outputs hold stable and ethii_trdy_o is low in HDR3/DATA/FLUSH.
- err_runt_o pulses the cycle after the offending tlast beat.

## Test plan
- dst 001122334455, src 66778899AABB, type 0800. Input:
  - 00112233
  - 44556677
  - 8899AABB
  - 08000102
  - 03040506
  - 0708xxxx (keep 1100, last)

  Required: header 001122334455/66778899AABB/0800, one pulse. Payload 01020304 (1111), 05060708 (1111, last).
- Same frame but last word 07xxxxxx (keep 1000) → out 05060700, keep 1110, last.
- Last word 07080900 (keep 1110) → 05060708 (1111, not last), then 09000000 (1000, last). ethii_trdy_o low during FLUSH.
- tlast on W1 → err_runt_o one pulse. No header, no payload. The next valid frame decodes correctly.
- Hold hdr_mac_rdy_i low across two frames → the second frame stalls at W3 and header 1 stays stable. Raising hdr_mac_rdy_i lets header 2 appear the next cycle.
- Randomly toggle user_trdy_i over a 64-byte payload; assert reset_n low mid-frame → output matches the input payload bytes exactly. After reset, all outputs are 0 and decode restarts at HDR0.
